// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;

    // Loader frame states.
    typedef enum logic [2:0] {
        ST_LEN_LO = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_DATA   = 3'd2,
        ST_CSUM   = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = 16;

    // True while a frame is being received (bytes may be accepted).
    function automatic logic frame_active(input state_e st);
        return (st == ST_LEN_LO) || (st == ST_LEN_HI) ||
               (st == ST_DATA)   || (st == ST_CSUM);
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Packs a byte stream into 32-bit little-endian words.
// word_valid/word_data are combinational so the caller can register the
// write strobe in the cycle right after the 4th byte is accepted.
module byte_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [1:0]  cnt_q;
    logic [31:0] shift_q;

    // Word completes on the last byte slot; newest byte enters at the top.
    always_comb begin
        word_valid = byte_valid && (cnt_q == 2'(BYTES_PER_WORD - 1));
        word_data  = {byte_data, shift_q[31:8]};
    end

    // Byte counter and shift register, cleared on reset or frame restart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= 2'd0;
            shift_q <= 32'd0;
        end else if (clr) begin
            cnt_q   <= 2'd0;
            shift_q <= 32'd0;
        end else if (byte_valid) begin
            cnt_q   <= cnt_q + 2'd1;
            shift_q <= word_data;
        end else begin
            cnt_q   <= cnt_q;
            shift_q <= shift_q;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Framed byte-stream loader: writes the program image into instruction
// memory and releases the core only after a matching XOR checksum.
module imem_boot_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error
);

    localparam logic [LEN_W:0] MAX_WORDS = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

    state_e              state_q;
    logic [7:0]          len_lo_q;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W:0]     word_cnt_q;
    logic [7:0]          xor_q;
    logic                in_ready_q;
    logic                imem_we_q;
    logic [ADDR_W-1:0]   imem_addr_q;
    logic [31:0]         imem_wdata_q;
    logic                core_reset_q;
    logic                done_q;
    logic                error_q;

    logic                accept_d;
    logic                asm_valid_d;
    logic                word_valid_d;
    logic [31:0]         word_data_d;
    logic [LEN_W:0]      n_ext_d;
    logic [ADDR_W:0]     word_cnt_inc_d;

    // start has priority over an incoming byte, so it masks the handshake.
    assign in_ready   = in_ready_q & ~start;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_reset = core_reset_q;
    assign done       = done_q;
    assign error      = error_q;

    // Handshake decode and frame-field arithmetic.
    always_comb begin
        accept_d       = in_valid & in_ready;
        asm_valid_d    = accept_d & (state_q == ST_DATA);
        n_ext_d        = {1'b0, in_data, len_lo_q};
        word_cnt_inc_d = word_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
    end

    byte_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clr        (start),
        .byte_valid (asm_valid_d),
        .byte_data  (in_data),
        .word_valid (word_valid_d),
        .word_data  (word_data_d)
    );

    // Frame FSM with its counters, checksum accumulator and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_LEN_LO;
            len_lo_q     <= 8'd0;
            len_q        <= {(ADDR_W+1){1'b0}};
            word_cnt_q   <= {(ADDR_W+1){1'b0}};
            xor_q        <= 8'd0;
            in_ready_q   <= 1'b1;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= {ADDR_W{1'b0}};
            imem_wdata_q <= 32'd0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            imem_we_q <= 1'b0;
            if (start) begin
                state_q      <= ST_LEN_LO;
                word_cnt_q   <= {(ADDR_W+1){1'b0}};
                xor_q        <= 8'd0;
                in_ready_q   <= 1'b1;
                core_reset_q <= 1'b1;
                done_q       <= 1'b0;
                error_q      <= 1'b0;
            end else begin
                case (state_q)
                    ST_LEN_LO: begin
                        if (accept_d) begin
                            len_lo_q <= in_data;
                            state_q  <= ST_LEN_HI;
                        end
                    end
                    ST_LEN_HI: begin
                        if (accept_d) begin
                            if (n_ext_d > MAX_WORDS) begin
                                state_q    <= ST_ERR;
                                in_ready_q <= 1'b0;
                                error_q    <= 1'b1;
                            end else if (n_ext_d == {(LEN_W+1){1'b0}}) begin
                                state_q <= ST_CSUM;
                            end else begin
                                len_q   <= n_ext_d[ADDR_W:0];
                                state_q <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (accept_d) begin
                            xor_q <= xor_q ^ in_data;
                        end
                        if (word_valid_d) begin
                            imem_we_q    <= 1'b1;
                            imem_addr_q  <= word_cnt_q[ADDR_W-1:0];
                            imem_wdata_q <= word_data_d;
                            word_cnt_q   <= word_cnt_inc_d;
                            if (word_cnt_inc_d == len_q) begin
                                state_q <= ST_CSUM;
                            end
                        end
                    end
                    ST_CSUM: begin
                        if (accept_d) begin
                            in_ready_q <= 1'b0;
                            if (in_data == xor_q) begin
                                state_q      <= ST_DONE;
                                done_q       <= 1'b1;
                                core_reset_q <= 1'b0;
                            end else begin
                                state_q <= ST_ERR;
                                error_q <= 1'b1;
                            end
                        end
                    end
                    ST_DONE, ST_ERR: begin
                        in_ready_q <= frame_active(state_q);
                    end
                    default: begin
                        state_q      <= ST_ERR;
                        in_ready_q   <= 1'b0;
                        core_reset_q <= 1'b1;
                        done_q       <= 1'b0;
                        error_q      <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: driver pushes expected writes and
// frame results into queues; a negedge monitor pops and compares.
module tb_imem_boot_loader;

    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_reset;
    logic              done;
    logic              error;

    int n_checks = 0;
    int n_fail   = 0;

    wr_t        exp_wr[$];
    logic [1:0] exp_res[$];   // {done, error}
    logic [31:0] fixed_words[2] = '{32'h00500093, 32'h00A00113};
    logic       prev_fin = 1'b0;

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every write strobe and every new frame result.
    always @(negedge clk) begin
        wr_t        e;
        logic [1:0] r;
        logic       fin;
        if (reset && imem_we) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = exp_wr.pop_front();
                check("write_addr", 32'(imem_addr), 32'(e.addr));
                check("write_data", imem_wdata, e.data);
            end
        end
        fin = done | error;
        if (reset && fin && !prev_fin) begin
            if (exp_res.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                r = exp_res.pop_front();
                check("result_done", 32'(done), 32'(r[1]));
                check("result_error", 32'(error), 32'(r[0]));
                check("result_core_reset", 32'(core_reset), 32'(!r[1]));
                check("writes_before_result", 32'(exp_wr.size()), 32'd0);
            end
        end
        prev_fin = fin;
    end

    // Present one byte and hold it until accepted; ends on a negedge.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int  budget = 0;
        bit  acc;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        forever begin
            #1 acc = in_ready;
            @(negedge clk);
            if (acc) break;
            budget++;
            if (budget > 50) begin
                check("byte_accept_timeout", 32'd1, 32'd0);
                break;
            end
        end
    endtask

    // Build a frame from plain word values, queue expectations, send it.
    task automatic run_frame(input int n, input bit corrupt, input bit gaps, input bit use_fixed);
        logic [7:0]  bytes[$];
        logic [7:0]  cs = 8'd0;
        logic [31:0] w;
        wr_t         e;
        bytes.push_back(n[7:0]);
        bytes.push_back(n[15:8]);
        if (n > MAX_WORDS) begin
            exp_res.push_back(2'b01);
        end else begin
            for (int i = 0; i < n; i++) begin
                w = use_fixed ? fixed_words[i] : $urandom();
                e.addr = i[ADDR_W-1:0];
                e.data = w;
                exp_wr.push_back(e);
                for (int k = 0; k < 4; k++) begin
                    bytes.push_back(8'((w >> (8 * k)) & 32'hFF));
                    cs = cs ^ 8'((w >> (8 * k)) & 32'hFF);
                end
            end
            bytes.push_back(corrupt ? (cs ^ 8'h5A) : cs);
            exp_res.push_back(corrupt ? 2'b01 : 2'b10);
        end
        foreach (bytes[j]) send_byte(bytes[j], gaps);
        in_valid = 1'b0;
        check("result_latency", 32'(done | error), 32'd1);
        check("ready_after_result", 32'(in_ready), 32'd0);
    endtask

    task automatic rearm();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (3) @(negedge clk);
        check_reset_values();
        reset = 1'b1;
        @(negedge clk);
        check_reset_values();

        // Known two-word image, good checksum.
        run_frame(2, 1'b0, 1'b0, 1'b1);
        check("done_core_reset", 32'(core_reset), 32'd0);

        // start together with a byte from DONE: byte must not be consumed.
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h02;
        #1 check("start_masks_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rearm_done", 32'(done), 32'd0);
        check("rearm_core_reset", 32'(core_reset), 32'd1);
        check("rearm_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Same image, bad checksum.
        run_frame(2, 1'b1, 1'b0, 1'b1);
        check("err_core_reset", 32'(core_reset), 32'd1);
        rearm();

        // Empty image, then oversize length.
        run_frame(0, 1'b0, 1'b0, 1'b0);
        rearm();
        run_frame(MAX_WORDS + 1, 1'b0, 1'b0, 1'b0);
        rearm();

        // Known image with a gappy in_valid.
        run_frame(2, 1'b0, 1'b1, 1'b1);
        rearm();

        // Restart mid-frame, then a random frame.
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        in_valid = 1'b0;
        rearm();
        run_frame(1, 1'b0, 1'b0, 1'b0);
        rearm();

        // Random frames.
        for (int f = 0; f < 6; f++) begin
            run_frame($urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            rearm();
        end

        // Full-capacity image.
        run_frame(MAX_WORDS, 1'b0, 1'b0, 1'b0);
        rearm();

        // Reset after five bytes of a two-word frame.
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h93, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h50, 1'b0);
        reset = 1'b0;
        #1 check_reset_values();
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        run_frame(2, 1'b0, 1'b0, 1'b1);

        repeat (2) @(negedge clk);
        check("pending_writes", 32'(exp_wr.size()), 32'd0);
        check("pending_results", 32'(exp_res.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
